max_pool_compare: RTL and testbench

Downstream stage of the max-pool address generator. Consumes the memory read data that returns for each 2x2 window element, tagged by the generator's one-hot `sel`, and keeps a running signed maximum. Emits one pooled value per window with a write address for the output feature-map memory. Asserts a sticky `done` once all `(matrix_size-1)^2` windows are written.

---
 rtl/max_pool_pkg.sv | 16 +
 rtl/signed_max2.sv | 16 +
 rtl/max_pool_compare.sv | 103 ++++++++++
 tb/tb_max_pool_compare.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/max_pool_pkg.sv
// max_pool_pkg: constants and helpers shared by the max-pool address
// generator and the compare stage.
//   SEL_*        one-hot element tags for the four positions of a 2x2 window
//   num_windows  number of 2x2 windows in a matrix_size x matrix_size input
package max_pool_pkg;

  localparam logic [3:0] SEL_TL = 4'b0001;
  localparam logic [3:0] SEL_TR = 4'b0010;
  localparam logic [3:0] SEL_BL = 4'b0100;
  localparam logic [3:0] SEL_BR = 4'b1000;

  function automatic int unsigned num_windows(input int unsigned matrix_size);
    return (matrix_size - 1) * (matrix_size - 1);
  endfunction

endpackage

// File: rtl/signed_max2.sv
// signed_max2: combinational signed maximum of two operands.
//   a, b : signed operands (data_width bits)
//   y    : a when a >= b, otherwise b (ties resolve to a)
module signed_max2 #(
  parameter int unsigned data_width = 16
) (
  input  logic signed [data_width-1:0] a,
  input  logic signed [data_width-1:0] b,
  output logic signed [data_width-1:0] y
);

  always_comb begin
    y = (a >= b) ? a : b;
  end

endmodule

// File: rtl/max_pool_compare.sv
// max_pool_compare: running signed maximum over the four elements of each
// 2x2 pooling window; emits one pooled value plus its output-map address per
// window, and flags completion once every window has been written.
//   clk, reset  clock / synchronous active-high reset
//   enable      when low, sel/data_in are ignored and state holds
//   sel         one-hot element tag (TL/TR/BL/BR), 0 = no data
//   data_in     signed element aligned with sel
//   out_base    output-map base address
//   max_out     pooled value (valid with max_valid)
//   max_valid   one-cycle emit strobe
//   wr_addr     out_base + window index
//   done        sticky: all windows emitted
//   err         sticky: element sequence violation seen
module max_pool_compare
  import max_pool_pkg::*;
#(
  parameter int unsigned matrix_size = 3,
  parameter int unsigned add_size    = 14,
  parameter int unsigned data_width  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [3:0]                   sel,
  input  logic signed [data_width-1:0] data_in,
  input  logic [add_size-1:0]          out_base,
  output logic signed [data_width-1:0] max_out,
  output logic                         max_valid,
  output logic [add_size-1:0]          wr_addr,
  output logic                         done,
  output logic                         err
);

  localparam int unsigned         NWIN     = num_windows(matrix_size);
  localparam logic [add_size-1:0] LAST_IDX = add_size'(NWIN - 1);

  logic signed [data_width-1:0] run_max;
  logic signed [data_width-1:0] cmp_max;
  logic                         have_first;
  logic [add_size-1:0]          window_idx;
  logic                         accept;
  logic                         sel_onehot;

  // Single comparator serves both the running update and the final emit:
  // in either case the result is max(run_max, data_in) with ties keeping run_max.
  signed_max2 #(.data_width(data_width)) u_max (
    .a (run_max),
    .b (data_in),
    .y (cmp_max)
  );

  always_comb begin
    accept     = enable && !done && (sel != 4'b0000);
    sel_onehot = (sel & (sel - 4'd1)) == 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_max    <= '0;
      have_first <= 1'b0;
      window_idx <= '0;
      max_out    <= '0;
      max_valid  <= 1'b0;
      wr_addr    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      max_valid <= 1'b0;
      if (accept) begin
        if (!sel_onehot) begin
          err <= 1'b1;
        end else begin
          unique case (sel)
            SEL_TL: begin
              // A repeated TL restarts the window on the new value.
              if (have_first) err <= 1'b1;
              run_max    <= data_in;
              have_first <= 1'b1;
            end
            SEL_TR, SEL_BL: begin
              if (have_first) run_max <= cmp_max;
              else            err     <= 1'b1;
            end
            SEL_BR: begin
              if (have_first) begin
                max_out    <= cmp_max;
                wr_addr    <= out_base + window_idx;
                max_valid  <= 1'b1;
                window_idx <= window_idx + 1'b1;
                have_first <= 1'b0;
                if (window_idx == LAST_IDX) done <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_max_pool_compare.sv
module tb_max_pool_compare;
  import max_pool_pkg::*;

  localparam int unsigned MS = 3;
  localparam int unsigned AW = 14;
  localparam int unsigned DW = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic [3:0]           sel;
  logic signed [DW-1:0] data_in;
  logic [AW-1:0]        out_base;
  logic signed [DW-1:0] max_out;
  logic                 max_valid;
  logic [AW-1:0]        wr_addr;
  logic                 done;
  logic                 err;

  int tests_run = 0;
  int tests_failed = 0;

  max_pool_compare #(
    .matrix_size (MS),
    .add_size    (AW),
    .data_width  (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .sel       (sel),
    .data_in   (data_in),
    .out_base  (out_base),
    .max_out   (max_out),
    .max_valid (max_valid),
    .wr_addr   (wr_addr),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic send(input logic [3:0] s, input int d);
    enable  = 1'b1;
    sel     = s;
    data_in = DW'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(4'b0000, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sel   = 4'b0000;
  endtask

  task automatic window(input int d0, input int d1, input int d2, input int d3);
    send(SEL_TL, d0);
    send(SEL_TR, d1);
    send(SEL_BL, d2);
    send(SEL_BR, d3);
  endtask

  task automatic expect_emit(input string tag, input int val, input int addr);
    check({tag, "_valid"}, max_valid, 1);
    check({tag, "_max"}, $signed(max_out), val);
    check({tag, "_addr"}, wr_addr, addr);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; sel = 4'b0000; data_in = '0; out_base = AW'(100);
    do_reset();
    check("rst_max_out", $signed(max_out), 0);
    check("rst_valid", max_valid, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    // Single window, then an all-negative window
    window(5, -3, 9, 2);
    expect_emit("w1", 9, 100);
    send(4'b0000, 0);
    check("w1_strobe_one_cycle", max_valid, 0);
    window(-7, -2, -9, -2);
    expect_emit("neg", -2, 101);
    check("neg_err", err, 0);

    // Full run with 2-cycle gaps
    do_reset();
    window(4, 1, 2, 3);   expect_emit("full0", 4, 100); check("full0_done", done, 0); idle(2);
    window(-1, 8, 8, 0);  expect_emit("full1", 8, 101); idle(2);
    window(1, -5, 0, 1);  expect_emit("full2", 1, 102); check("full2_done", done, 0); idle(2);
    window(6, 6, -6, 2);  expect_emit("full3", 6, 103); check("full3_done", done, 1);
    window(50, 60, 70, 80);
    check("post_done_valid", max_valid, 0);
    check("post_done_max", $signed(max_out), 6);
    send(SEL_TR, 1);
    check("post_done_err", err, 0);
    check("post_done_sticky", done, 1);

    // Sequence fault then clean window
    do_reset();
    send(SEL_TR, 33);
    check("seq_err", err, 1);
    check("seq_valid", max_valid, 0);
    window(-4, 11, 3, 7);
    expect_emit("seq_clean", 11, 100);

    // Non-one-hot tag is dropped
    do_reset();
    send(4'b0011, 9);
    check("nonhot_err", err, 1);
    check("nonhot_valid", max_valid, 0);

    // enable low while BR is presented
    do_reset();
    send(SEL_TL, 3); send(SEL_TR, 12); send(SEL_BL, -1);
    enable = 1'b0; sel = SEL_BR; data_in = DW'(20);
    @(posedge clk); #1;
    check("en_low_valid_a", max_valid, 0);
    @(posedge clk); #1;
    check("en_low_valid_b", max_valid, 0);
    send(SEL_BR, 20);
    expect_emit("en_back", 20, 100);

    // Reset mid-window; BR driven during reset must be ignored
    do_reset();
    out_base = AW'(200);
    send(SEL_TL, 90); send(SEL_TR, 95);
    enable = 1'b1; sel = SEL_BR; data_in = DW'(99);
    do_reset();
    check("mid_rst_valid", max_valid, 0);
    window(1, 2, 3, 4);
    expect_emit("mid_rst", 4, 200);
    check("mid_rst_err", err, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
